// File: rtl/ula_sequenciador_if.sv
// Command and response channels between the datapath control and ula_sequenciador.
// The master drives commands and takes responses; the slave is the sequencer itself.
interface ula_sequenciador_if #(
  parameter int LARGURA = 32
);
  logic               cmd_valido;
  logic               cmd_pronto;
  logic [2:0]         cmd_op;
  logic [LARGURA-1:0] cmd_x;
  logic [LARGURA-1:0] cmd_y;
  logic               cmd_acum;
  logic               resp_valido;
  logic               resp_pronto;
  logic [LARGURA-1:0] resp_resultado;
  logic               resp_N;
  logic               resp_Z;
  logic               resp_erro;

  modport master (
    output cmd_valido, cmd_op, cmd_x, cmd_y, cmd_acum, resp_pronto,
    input  cmd_pronto, resp_valido, resp_resultado, resp_N, resp_Z, resp_erro
  );

  modport slave (
    input  cmd_valido, cmd_op, cmd_x, cmd_y, cmd_acum, resp_pronto,
    output cmd_pronto, resp_valido, resp_resultado, resp_N, resp_Z, resp_erro
  );
endinterface

// File: rtl/ula_sequenciador.sv
// Issues one command at a time to a combinational ULA, captures its result and flags,
// and returns them over a response handshake, with an accumulator and a division-by-zero guard.
module ula_sequenciador #(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  ula_sequenciador_if.slave  cmd_resp,
  output logic [2:0]         ula_selecao,
  output logic [LARGURA-1:0] ula_X,
  output logic [LARGURA-1:0] ula_Y,
  input  logic [LARGURA-1:0] ula_resultado,
  input  logic               ula_N,
  input  logic               ula_Z,
  output logic [LARGURA-1:0] acumulador
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EMITE    = 2'd1,
    RESPONDE = 2'd2
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [2:0]         selecao_q, selecao_d;
  logic [LARGURA-1:0] x_q, x_d;
  logic [LARGURA-1:0] y_q, y_d;
  logic [LARGURA-1:0] acum_q, acum_d;
  logic               resp_valido_q, resp_valido_d;
  logic [LARGURA-1:0] resp_resultado_q, resp_resultado_d;
  logic               resp_n_q, resp_n_d;
  logic               resp_z_q, resp_z_d;
  logic               resp_erro_q, resp_erro_d;

  logic               div_zero;
  logic [LARGURA-1:0] x_efetivo;

  assign div_zero  = (cmd_resp.cmd_op == 3'b110) && (cmd_resp.cmd_y == '0);
  assign x_efetivo = cmd_resp.cmd_acum ? acum_q : cmd_resp.cmd_x;

  always_comb begin
    estado_d         = estado_q;
    selecao_d        = selecao_q;
    x_d              = x_q;
    y_d              = y_q;
    acum_d           = acum_q;
    resp_valido_d    = resp_valido_q;
    resp_resultado_d = resp_resultado_q;
    resp_n_d         = resp_n_q;
    resp_z_d         = resp_z_q;
    resp_erro_d      = resp_erro_q;
    unique case (estado_q)
      OCIOSO: begin
        if (cmd_resp.cmd_valido) begin
          if (div_zero) begin
            // The ULA is never driven for a division by zero; the error answer is immediate.
            resp_resultado_d = {LARGURA{1'b1}};
            resp_n_d         = 1'b1;
            resp_z_d         = 1'b0;
            resp_erro_d      = 1'b1;
            resp_valido_d    = 1'b1;
            estado_d         = RESPONDE;
          end else begin
            selecao_d = cmd_resp.cmd_op;
            x_d       = x_efetivo;
            y_d       = cmd_resp.cmd_y;
            estado_d  = EMITE;
          end
        end
      end
      EMITE: begin
        resp_resultado_d = ula_resultado;
        resp_n_d         = ula_N;
        resp_z_d         = ula_Z;
        resp_erro_d      = 1'b0;
        resp_valido_d    = 1'b1;
        acum_d           = ula_resultado;
        estado_d         = RESPONDE;
      end
      RESPONDE: begin
        if (cmd_resp.resp_pronto) begin
          resp_valido_d = 1'b0;
          estado_d      = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q         <= OCIOSO;
      selecao_q        <= '0;
      x_q              <= '0;
      y_q              <= '0;
      acum_q           <= '0;
      resp_valido_q    <= 1'b0;
      resp_resultado_q <= '0;
      resp_n_q         <= 1'b0;
      resp_z_q         <= 1'b0;
      resp_erro_q      <= 1'b0;
    end else begin
      estado_q         <= estado_d;
      selecao_q        <= selecao_d;
      x_q              <= x_d;
      y_q              <= y_d;
      acum_q           <= acum_d;
      resp_valido_q    <= resp_valido_d;
      resp_resultado_q <= resp_resultado_d;
      resp_n_q         <= resp_n_d;
      resp_z_q         <= resp_z_d;
      resp_erro_q      <= resp_erro_d;
    end
  end

  assign cmd_resp.cmd_pronto     = (estado_q == OCIOSO);
  assign cmd_resp.resp_valido    = resp_valido_q;
  assign cmd_resp.resp_resultado = resp_resultado_q;
  assign cmd_resp.resp_N         = resp_n_q;
  assign cmd_resp.resp_Z         = resp_z_q;
  assign cmd_resp.resp_erro      = resp_erro_q;
  assign ula_selecao             = selecao_q;
  assign ula_X                   = x_q;
  assign ula_Y                   = y_q;
  assign acumulador              = acum_q;

endmodule
